// File: rtl/ftq_pkg.sv
// ftq_pkg: shared types and default sizing for the fetch target queue controller
package ftq_pkg;
  localparam int DEPTH_D = 16;
  localparam int PTRW_D = 4;
  localparam int FLUSH_CYC_D = 2;
  typedef enum logic [1:0] {RUN, CLEAN, DRAIN} state_t;
  typedef struct packed {
    logic valid;
    logic yn;
  } skid_t;
endpackage

// File: rtl/ftq_upd_skid.sv
// ftq_upd_skid: one-entry holding slot for a retired branch awaiting the TAGE update port
module ftq_upd_skid
  import ftq_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  load,
  input  logic  yn,
  input  logic  pop,
  output skid_t q
);
  // clear wins, a same-cycle refill beats the pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= clr ? '0 : load ? {1'b1, yn} : pop ? '0 : q;
endmodule

// File: rtl/ftq_ctrl.sv
// ftq_ctrl: FTQ enqueue/dequeue sequencing, occupancy, backpressure and flush control
module ftq_ctrl
  import ftq_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int PTRW = PTRW_D,
  parameter int FLUSH_CYC = FLUSH_CYC_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ftq_stop,
  input  logic            ftq_flash,
  input  logic            predict_able,
  input  logic            rob_branch,
  input  logic            rob_branch_yn,
  input  logic            tage_busy,
  output logic            rob_rdy,
  output logic            fifo_wable,
  output logic            fifo_rable,
  output logic            fifo_clean,
  output logic            ftq_req,
  output logic [PTRW-1:0] enq_ptr,
  output logic [PTRW-1:0] deq_ptr,
  output logic [PTRW:0]   count,
  output logic            upd_valid,
  output logic            upd_right,
  output logic            underflow
);
  state_t state, state_nx;
  skid_t skid;
  logic [2:0] dcnt;
  logic [PTRW:0] count_nx;
  logic run, enq_fire, upd_fire, uflow, take;
  assign run = state == RUN;
  assign enq_fire = predict_able & ~ftq_stop & ~ftq_req & run;
  assign upd_fire = skid.valid & ~tage_busy & run;
  assign rob_rdy = run & (~skid.valid | upd_fire);
  assign uflow = rob_branch & rob_rdy & (count == '0) & ~enq_fire;
  assign take = rob_branch & rob_rdy & ~uflow;
  assign fifo_wable = enq_fire;
  assign fifo_rable = upd_fire;
  assign fifo_clean = state == CLEAN;
  assign upd_valid = skid.valid;
  assign upd_right = skid.yn;
  ftq_upd_skid u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == CLEAN),
    .load (take),
    .yn   (rob_branch_yn),
    .pop  (upd_fire),
    .q    (skid)
  );
  // next occupancy and flush state; a flash anywhere restarts the clean
  always_comb begin
    count_nx = run ? count + (PTRW+1)'(enq_fire) - (PTRW+1)'(upd_fire) : '0;
    state_nx = (ftq_flash | (upd_fire & ~skid.yn)) ? CLEAN :
               (state == CLEAN) ? DRAIN :
               (state == DRAIN && dcnt == '0) ? RUN : state;
  end
  // FSM, drain timer, pointers, occupancy and registered status flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      dcnt <= '0;
      enq_ptr <= '0;
      deq_ptr <= '0;
      count <= '0;
      ftq_req <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nx;
      dcnt <= (state == CLEAN) ? 3'(FLUSH_CYC - 1) : (dcnt != '0) ? dcnt - 3'd1 : dcnt;
      enq_ptr <= run ? enq_ptr + PTRW'(enq_fire) : '0;
      deq_ptr <= run ? deq_ptr + PTRW'(upd_fire) : '0;
      count <= count_nx;
      ftq_req <= (count_nx >= (PTRW+1)'(DEPTH)) | (state_nx != RUN);
      underflow <= underflow | uflow;
    end
endmodule

// File: tb/tb_ftq_ctrl.sv
// tb_ftq_ctrl: directed vector table plus multi-cycle corner sequences for ftq_ctrl
module tb_ftq_ctrl;
  logic clk = 0, rst_n = 0;
  logic ftq_stop, ftq_flash, predict_able, rob_branch, rob_branch_yn, tage_busy;
  logic rob_rdy, fifo_wable, fifo_rable, fifo_clean, ftq_req, upd_valid, upd_right, underflow;
  logic [3:0] enq_ptr, deq_ptr;
  logic [4:0] count;
  int total = 0, bad = 0;

  ftq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ftq_stop(ftq_stop), .ftq_flash(ftq_flash),
    .predict_able(predict_able), .rob_branch(rob_branch), .rob_branch_yn(rob_branch_yn),
    .tage_busy(tage_busy), .rob_rdy(rob_rdy), .fifo_wable(fifo_wable),
    .fifo_rable(fifo_rable), .fifo_clean(fifo_clean), .ftq_req(ftq_req),
    .enq_ptr(enq_ptr), .deq_ptr(deq_ptr), .count(count), .upd_valid(upd_valid),
    .upd_right(upd_right), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stop, flash, pred, rob, yn, busy;
    logic wable, rable, rdy;
    logic [4:0] cnt;
    logic [3:0] enq, deq;
    logic upd, uf;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, act, exp);
    end
  endtask

  task automatic drv(input logic s, f, p, r, y, b);
    ftq_stop = s; ftq_flash = f; predict_able = p;
    rob_branch = r; rob_branch_yn = y; tage_busy = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    #2 rst_n = 0;
    #2 rst_n = 1;
    tick();
  endtask

  initial begin
    v[0] = '{0,0,1,0,0,0, 1,0,1, 5'd1,4'd1,4'd0, 0,0};
    v[1] = '{0,0,1,1,1,0, 1,0,1, 5'd2,4'd2,4'd0, 1,0};
    v[2] = '{0,0,0,0,0,1, 0,0,0, 5'd2,4'd2,4'd0, 1,0};
    v[3] = '{0,0,0,0,0,0, 0,1,1, 5'd1,4'd2,4'd1, 0,0};
    v[4] = '{1,0,1,0,0,0, 0,0,1, 5'd1,4'd2,4'd1, 0,0};
    v[5] = '{0,0,0,1,1,0, 0,0,1, 5'd1,4'd2,4'd1, 1,0};
    v[6] = '{0,0,0,0,0,0, 0,1,1, 5'd0,4'd2,4'd2, 0,0};
    v[7] = '{0,0,0,1,1,0, 0,0,1, 5'd0,4'd2,4'd2, 0,1};
    v[8] = '{0,0,1,1,1,0, 1,0,1, 5'd1,4'd3,4'd2, 1,1};
    v[9] = '{0,0,0,0,0,0, 0,1,1, 5'd0,4'd3,4'd3, 0,1};
    drv(0,0,0,0,0,0);
    #12;
    chk("rst_count", count, 0);
    chk("rst_req", ftq_req, 0);
    chk("rst_clean", fifo_clean, 0);
    chk("rst_upd", upd_valid, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_ptrs", {enq_ptr, deq_ptr}, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drv(v[i].stop, v[i].flash, v[i].pred, v[i].rob, v[i].yn, v[i].busy);
      #1;
      chk($sformatf("v%0d_wable", i), fifo_wable, v[i].wable);
      chk($sformatf("v%0d_rable", i), fifo_rable, v[i].rable);
      chk($sformatf("v%0d_rdy", i), rob_rdy, v[i].rdy);
      tick();
      chk($sformatf("v%0d_count", i), count, v[i].cnt);
      chk($sformatf("v%0d_enq", i), enq_ptr, v[i].enq);
      chk($sformatf("v%0d_deq", i), deq_ptr, v[i].deq);
      chk($sformatf("v%0d_upd", i), upd_valid, v[i].upd);
      chk($sformatf("v%0d_uf", i), underflow, v[i].uf);
    end

    // fill to full, then one rejected request
    drv(0,0,0,0,0,0);
    do_reset();
    chk("reset_clears_uf", underflow, 0);
    for (int i = 0; i < 16; i++) begin
      drv(0,0,1,0,0,0);
      #1;
      chk("fill_wable", fifo_wable, 1);
      tick();
    end
    chk("fill_count", count, 16);
    chk("fill_req", ftq_req, 1);
    chk("fill_enq_wrap", enq_ptr, 0);
    #1;
    chk("full_reject", fifo_wable, 0);
    tick();
    chk("full_count_hold", count, 16);

    // steady enqueue+retire at occupancy 5
    drv(0,0,0,0,0,0);
    do_reset();
    drv(0,0,1,0,0,0);
    repeat (5) tick();
    drv(0,0,0,1,1,0);
    tick();
    chk("tp_prime_count", count, 5);
    for (int i = 0; i < 20; i++) begin
      drv(0,0,1,1,1,0);
      #1;
      chk("tp_wable", fifo_wable, 1);
      chk("tp_rable", fifo_rable, 1);
      tick();
      chk("tp_count", count, 5);
    end
    chk("tp_deq", deq_ptr, 4);
    chk("tp_enq", enq_ptr, 9);
    drv(0,0,0,0,0,0);
    tick();
    chk("tp_drain_count", count, 4);

    // TAGE backpressure on a held update
    drv(0,0,0,1,1,1);
    #1;
    chk("bp_c1_rdy", rob_rdy, 1);
    tick();
    chk("bp_c1_upd", upd_valid, 1);
    for (int i = 0; i < 2; i++) begin
      drv(0,0,0,0,0,1);
      #1;
      chk("bp_hold_rdy", rob_rdy, 0);
      chk("bp_hold_rable", fifo_rable, 0);
      tick();
      chk("bp_hold_count", count, 4);
    end
    drv(0,0,0,0,0,0);
    #1;
    chk("bp_release_rable", fifo_rable, 1);
    tick();
    chk("bp_release_count", count, 3);
    chk("bp_release_upd", upd_valid, 0);

    // mispredict flush from occupancy 6
    drv(0,0,1,0,0,0);
    repeat (3) tick();
    chk("mp_count6", count, 6);
    drv(0,0,0,1,0,0);
    tick();
    chk("mp_right0", upd_right, 0);
    drv(0,0,1,0,0,0);
    #1;
    chk("mp_fire", fifo_rable, 1);
    tick();
    chk("mp_clean", fifo_clean, 1);
    chk("mp_clean_req", ftq_req, 1);
    chk("mp_clean_rdy", rob_rdy, 0);
    tick();
    chk("mp_d1_clean", fifo_clean, 0);
    chk("mp_d1_count", count, 0);
    chk("mp_d1_ptrs", {enq_ptr, deq_ptr}, 0);
    chk("mp_d1_req", ftq_req, 1);
    chk("mp_d1_wable", fifo_wable, 0);
    tick();
    chk("mp_d2_req", ftq_req, 1);
    chk("mp_d2_rdy", rob_rdy, 0);
    drv(0,0,0,0,0,0);
    tick();
    chk("mp_run_req", ftq_req, 0);
    chk("mp_run_rdy", rob_rdy, 1);

    // flash during drain restarts the clean
    drv(0,1,0,0,0,0);
    tick();
    chk("fd_clean1", fifo_clean, 1);
    drv(0,0,0,0,0,0);
    tick();
    chk("fd_drain1", fifo_clean, 0);
    drv(0,1,0,0,0,0);
    tick();
    chk("fd_clean2", fifo_clean, 1);
    drv(0,0,0,0,0,0);
    tick();
    tick();
    chk("fd_d2_req", ftq_req, 1);
    tick();
    chk("fd_run_req", ftq_req, 0);

    // underflow then asynchronous reset mid-drain
    drv(0,0,0,1,1,0);
    tick();
    chk("uf_set", underflow, 1);
    chk("uf_count", count, 0);
    chk("uf_upd", upd_valid, 0);
    drv(0,1,0,0,0,0);
    tick();
    drv(0,0,0,0,0,0);
    tick();
    chk("uf_in_drain", ftq_req, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_req", ftq_req, 0);
    chk("ar_uf", underflow, 0);
    chk("ar_clean", fifo_clean, 0);
    chk("ar_count", count, 0);
    #2 rst_n = 1;
    tick();
    chk("ar_run_rdy", rob_rdy, 1);
    chk("ar_no_clean", fifo_clean, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
